// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - APB completer with RW register bank, read-only ID word and programmable wait states
//
// Ports:
//   clk       in   1   clock, rising edge
//   reset_n   in   1   asynchronous active-low reset
//   PSELx     in   1   slave select
//   PENABLE   in   1   access-phase strobe
//   PADDR     in  32   byte address
//   PWRITE    in   1   1 = write, 0 = read
//   PWDATA    in  32   write data
//   PREADY    out  1   transfer complete, one-cycle pulse (registered)
//   PRDATA    out 32   read data, valid with PREADY (registered)
//   PSLVERR   out  1   error response, valid with PREADY (registered)
//   ctrl_out  out 32   live value of register 0
module apb_regfile_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hABCD_1200,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA9B5_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic [31:0] ctrl_out
);

  localparam int          IDX_W     = $clog2(NUM_REGS);
  localparam logic [31:0] ID_OFFSET = 32'(NUM_REGS * 4);
  localparam logic [3:0]  CNT_INIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       cnt;
  logic [31:0]      regs [NUM_REGS];

  // Transfer attributes captured in the setup phase; the bus is ignored after that.
  logic             lat_write;
  logic             lat_err;
  logic             lat_is_id;
  logic [IDX_W-1:0] lat_idx;
  logic [31:0]      lat_wdata;

  // Address decode on the live bus, only consumed when latching a setup.
  logic [31:0]      offset;
  logic             dec_is_id;
  logic             dec_err;
  logic [IDX_W-1:0] dec_idx;

  assign offset    = PADDR - BASE_ADDR;
  assign dec_is_id = (offset == ID_OFFSET);
  assign dec_idx   = offset[IDX_W+1:2];
  // Wrap-around of the subtraction makes addresses below BASE_ADDR huge, so one compare covers both sides.
  assign dec_err   = (offset[1:0] != 2'b00) || (offset > ID_OFFSET) || (dec_is_id && PWRITE);

  logic setup;
  logic access_edge;
  logic commit;
  logic latch_en;
  logic wr_en;
  logic        pready_nxt;
  logic        pslverr_nxt;
  logic [31:0] prdata_nxt;

  assign setup       = PSELx && !PENABLE;
  assign access_edge = PSELx && PENABLE;
  assign commit      = (state == S_ACCESS) && access_edge && (cnt == 4'd0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (setup) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (!PSELx)      state_nxt = S_IDLE;
        else if (commit) state_nxt = S_DONE;
      end
      S_DONE: begin
        // A setup on the edge that ends DONE starts the next transfer without an idle cycle.
        state_nxt = setup ? S_ACCESS : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath control; response outputs are the registered form of these values
  always_comb begin
    latch_en    = setup && ((state == S_IDLE) || (state == S_DONE));
    wr_en       = commit && lat_write && !lat_err;
    pready_nxt  = commit;
    pslverr_nxt = commit && lat_err;
    prdata_nxt  = 32'h0;
    if (commit && !lat_write && !lat_err) begin
      prdata_nxt = lat_is_id ? ID_VALUE : regs[lat_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= 32'h0;
    end else begin
      PREADY  <= pready_nxt;
      PSLVERR <= pslverr_nxt;
      PRDATA  <= prdata_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_is_id <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'h0;
    end else if (latch_en) begin
      cnt       <= CNT_INIT;
      lat_write <= PWRITE;
      lat_err   <= dec_err;
      lat_is_id <= dec_is_id;
      lat_idx   <= dec_idx;
      lat_wdata <= PWDATA;
    end else if ((state == S_ACCESS) && access_edge && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wr_en) begin
      regs[lat_idx] <= lat_wdata;
    end
  end

  assign ctrl_out = regs[0];

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

APB completer that sits directly downstream of `apb_master` and consumes its `PSELx`/`PENABLE`/`PADDR`/`PWDATA`/`PWRITE` bus. It implements a bank of 32-bit read/write registers plus one read-only ID word. It returns `PREADY` after a programmable number of wait states. `PSLVERR` flags bad accesses. Register 0 is exported as a control word for downstream logic.

## Interface
- `BASE_ADDR`, 32'hABCD_1200, byte address of register 0.
- `NUM_REGS`, 16, number of RW registers (power of two, 2–64).
- `WAIT_STATES`, 2, extra access-phase cycles before `PREADY` (0–15).
- `ID_VALUE`, 32'hA9B5_0001, read-only word at offset `NUM_REGS*4`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `PSELx`  in  1  slave select.
- `PENABLE`  in  1  access-phase strobe.
- `PADDR`  in  32  byte address.
- `PWRITE`  in  1  1 = write, 0 = read.
- `PWDATA`  in  32  write data.
- `PREADY`  out  1  transfer complete (registered).
- `PRDATA`  out  32  read data (registered).
- `PSLVERR`  out  1  error response, valid only with `PREADY` (registered).
- `ctrl_out`  out  32  live value of register 0.

## Operation
- Offset = `PADDR − BASE_ADDR` (32-bit unsigned wrap).
- An access is valid when `offset[1:0]==0` and `offset ≤ NUM_REGS*4`.
- RW index = `offset[$clog2(NUM_REGS)+1:2]`.
- `offset == NUM_REGS*4` selects the ID word: read returns `ID_VALUE`; write is an error.
- Error cases are misaligned, out of range, or a write to the ID word.
  - `PSLVERR=1` with `PREADY`.
  - No register is modified.
  - `PRDATA=0`.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: at an edge with `PSELx=1 && PENABLE=0` (setup), latch `PADDR`/`PWRITE`/`PWDATA` and the decode result, load `cnt=WAIT_STATES`, and go to ACCESS. `PENABLE=1` without a prior setup is ignored.
  - ACCESS: at each edge with `PSELx && PENABLE`, if `cnt≠0` decrement it. If `cnt==0`, commit the access and go to DONE:
    - perform the write, or load `PRDATA`;
    - set `PREADY=1`;
    - set `PSLVERR` per the decode.
  - ACCESS abort: at an edge with `PSELx=0`, go to IDLE with no commit and `PREADY` stays 0.
  - DONE: outputs are held for exactly one cycle. At the next edge `PREADY`, `PSLVERR` and `PRDATA` clear to 0. If that edge is also a new setup, go to ACCESS (back-to-back); otherwise go to IDLE.
- Address, data and direction come from the setup-phase latch. Changes on the bus during ACCESS are ignored.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert externally):
  - state IDLE, `cnt=0`;
  - all registers 0;
  - `PREADY=0`, `PRDATA=0`, `PSLVERR=0`, `ctrl_out=0`.
- Reset mid-transfer discards the transfer and produces no write.
- Setup sampled at edge N → `PREADY` high during the cycle following edge N+1+`WAIT_STATES`.
  - The master samples it at edge N+2+`WAIT_STATES`.
  - Access phase = `WAIT_STATES+2` cycles (minimum 2).
- A write takes effect at the commit edge; `ctrl_out` reflects a write to register 0 in the DONE cycle.
- A read issued immediately after a write to the same register returns the new value.
- Back-to-back: a setup on the DONE→ edge starts the next transfer with no idle cycle.
- `PREADY` is never high for more than one consecutive cycle per transfer.

## Test plan
- Write then read, with `WAIT_STATES=2`:
  - setup at edge N, write `PADDR=32'hABCD_1234`, `PWDATA=32'hFACE_CAFE` → `PREADY` high only during the cycle after edge N+3, `PSLVERR=0`;
  - then a read of 32'hABCD_1234 → `PRDATA=32'hFACE_CAFE` with `PREADY`.
- `ctrl_out` / ID word:
  - write 32'h0000_00A5 to 32'hABCD_1200 → `ctrl_out=32'h0000_00A5` from the DONE cycle;
  - read 32'hABCD_1240 → `PRDATA=32'hA9B5_0001`, `PSLVERR=0`.
- Errors:
  - write to 32'hABCD_1240 → `PSLVERR=1`, and a later read still returns `ID_VALUE`;
  - read 32'hABCD_1236 → `PSLVERR=1`, `PRDATA=0`;
  - read 32'hABCD_1300 → `PSLVERR=1`.
- Abort and reset:
  - drop `PSELx` mid-ACCESS during a write of 32'h1111_1111 to 32'hABCD_1204 → no `PREADY`, and a later read returns 32'h0000_0000;
  - assert `reset_n=0` mid-transfer → all outputs 0 immediately, and register contents read back as 0.
- Back-to-back, `WAIT_STATES=0`: three consecutive writes with setup on each DONE edge → each `PREADY` pulse is 1 cycle, spaced 2 cycles apart, and all three values read back correctly.
- Protocol robustness: `PENABLE=1` asserted while IDLE with no setup → no `PREADY`, no state change.
